apb_wait_slave: RTL

APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

---
 rtl/apb_wait_slave.sv | 103 ++++++++++
 1 files changed

// File: rtl/apb_wait_slave.sv
// rtl/apb_wait_slave.sv - APB slave with programmable wait states, six GP registers and a completion counter
module apb_wait_slave #(
  parameter logic [2:0] DEFAULT_WAIT = 3'd0
) (
  input  logic        PCLK,
  input  logic        Prst,
  input  logic        PSELx,
  input  logic        Pen,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_READY} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_wait;
  logic [31:0] r_gp [0:7];
  logic [31:0] r_count;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;

  logic [2:0]  w_sel;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_sel    = Paddr[4:2];
  assign w_err    = (Paddr[11:5] != 7'd0) || (Pwrite && (w_sel == 3'd7));
  assign w_unused = &{1'b0, Paddr[31:12], Paddr[1:0]};

  // Slots 0 and 7 of r_gp stay zero; CTRL and COUNT live in their own registers.
  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      3'd0:    w_rdata = {29'd0, r_wait};
      3'd7:    w_rdata = r_count;
      default: w_rdata = r_gp[w_sel];
    endcase
  end

  always_ff @(posedge PCLK or negedge Prst) begin
    if (!Prst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_wait    <= DEFAULT_WAIT;
      r_count   <= 32'd0;
      r_prdata  <= 32'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < 8; i++) r_gp[i] <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= 32'd0;
          if (PSELx && !Pen) begin
            r_state <= S_ACCESS;
            r_cnt   <= r_wait;
          end
        end
        S_ACCESS: begin
          if (!PSELx) begin
            r_state <= S_IDLE;
          end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_state   <= S_READY;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            if (!w_err) begin
              r_count <= r_count + 32'd1;
              if (Pwrite) begin
                if (w_sel == 3'd0) r_wait <= Pwdata[2:0];
                else               r_gp[w_sel] <= Pwdata;
              end else begin
                r_prdata <= w_rdata;
              end
            end
          end
        end
        S_READY: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Prdata  = r_prdata;
  assign Pready  = r_pready;
  assign Pslverr = r_pslverr;

endmodule
